// File: rtl/fhg_tx_pkt_arbiter.sv
// rtl/fhg_tx_pkt_arbiter.sv - packet-level round-robin arbiter onto one TX AXI-Stream port
//
// Shares the single CASPER TX stream between NUM_SRC packet sources. A grant
// is held from the first beat to tlast, so packets never interleave. New
// grants are withheld while tx_pause is high, and a programmable idle gap
// follows every packet.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   s_t*           per-source stream inputs, source k in slice k of each bus
//   s_tready       per-source ready, only the granted source sees m_tready
//   m_t*           merged stream towards the TX adapter
//   tx_pause       DCMAC almost-full, only consulted when choosing a new grant
//   grant_id       current or most recent granted source
//   busy           high while a packet is being transferred
//   pkt_cnt        count of accepted tlast beats, wraps at 2^32
//   err_overlong   sticky flag, a packet ran past MAX_BEATS beats
module fhg_tx_pkt_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 1024,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int MIN_GAP    = 1,
  parameter int MAX_BEATS  = 64,
  parameter int GW         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_SRC*KEEP_WIDTH-1:0] s_tkeep,
  input  logic [NUM_SRC-1:0]            s_tvalid,
  input  logic [NUM_SRC-1:0]            s_tlast,
  input  logic [NUM_SRC-1:0]            s_tuser,
  output logic [NUM_SRC-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic [KEEP_WIDTH-1:0]         m_tkeep,
  output logic                          m_tvalid,
  output logic                          m_tlast,
  output logic                          m_tuser,
  input  logic                          m_tready,
  input  logic                          tx_pause,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy,
  output logic [31:0]                   pkt_cnt,
  output logic                          err_overlong
);

  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam int CW = 4;

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  state_t          state, state_next;
  logic [GW-1:0]   grant_next;
  logic [GW-1:0]   last_grant, last_grant_next;
  logic [BW-1:0]   beat_cnt, beat_cnt_next;
  logic [CW-1:0]   gap_cnt, gap_cnt_next;
  logic [31:0]     pkt_cnt_next;
  logic            err_next;

  logic            pick_found;
  logic [GW-1:0]   pick_idx;
  int              rr_idx;

  logic            sel_tvalid;
  logic            sel_tlast;
  logic            accept;

  // Round-robin scan starting just after the last source that completed a
  // packet; the first valid source found wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    rr_idx     = 0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      rr_idx = (int'(last_grant) + i) % NUM_SRC;
      if (!pick_found && s_tvalid[rr_idx]) begin
        pick_found = 1'b1;
        pick_idx   = GW'(rr_idx);
      end
    end
  end

  // Datapath mux follows grant_id in every state; only valid/ready are gated.
  assign sel_tvalid = s_tvalid[grant_id];
  assign sel_tlast  = s_tlast[grant_id];
  assign m_tdata    = s_tdata[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
  assign m_tkeep    = s_tkeep[int'(grant_id)*KEEP_WIDTH +: KEEP_WIDTH];
  assign m_tlast    = sel_tlast;
  assign m_tuser    = s_tuser[grant_id];
  assign busy       = (state == XFER);
  assign m_tvalid   = busy & sel_tvalid;
  assign accept     = m_tvalid & m_tready;
  assign s_tready   = (busy && m_tready) ? (NUM_SRC'(1) << grant_id) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant_id     <= '0;
      last_grant   <= GW'(NUM_SRC - 1);
      beat_cnt     <= '0;
      gap_cnt      <= '0;
      pkt_cnt      <= '0;
      err_overlong <= 1'b0;
    end else begin
      state        <= state_next;
      grant_id     <= grant_next;
      last_grant   <= last_grant_next;
      beat_cnt     <= beat_cnt_next;
      gap_cnt      <= gap_cnt_next;
      pkt_cnt      <= pkt_cnt_next;
      err_overlong <= err_next;
    end
  end

  always_comb begin
    state_next      = state;
    grant_next      = grant_id;
    last_grant_next = last_grant;
    beat_cnt_next   = beat_cnt;
    gap_cnt_next    = gap_cnt;
    pkt_cnt_next    = pkt_cnt;
    err_next        = err_overlong;
    case (state)
      IDLE: begin
        if (!tx_pause && pick_found) begin
          grant_next    = pick_idx;
          beat_cnt_next = '0;
          state_next    = XFER;
        end
      end
      XFER: begin
        if (accept) begin
          // Saturate so a runaway packet cannot wrap the counter and mask itself.
          if (beat_cnt != BW'(MAX_BEATS)) begin
            beat_cnt_next = beat_cnt + 1'b1;
          end
          if (beat_cnt == BW'(MAX_BEATS - 1) && !sel_tlast) begin
            err_next = 1'b1;
          end
          if (sel_tlast) begin
            pkt_cnt_next    = pkt_cnt + 32'd1;
            last_grant_next = grant_id;
            gap_cnt_next    = '0;
            state_next      = (MIN_GAP > 0) ? GAP : IDLE;
          end
        end
      end
      GAP: begin
        if (int'(gap_cnt) >= MIN_GAP - 1) begin
          state_next = IDLE;
        end else begin
          gap_cnt_next = gap_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fhg_tx_pkt_arbiter.sv
// tb/tb_fhg_tx_pkt_arbiter.sv - scoreboard bench for fhg_tx_pkt_arbiter
module tb_fhg_tx_pkt_arbiter;

  localparam int NUM_SRC    = 4;
  localparam int DATA_WIDTH = 1024;
  localparam int KEEP_WIDTH = 128;
  localparam int MIN_GAP    = 1;
  localparam int MAX_BEATS  = 64;
  localparam int GW         = 2;
  localparam int DEPTH      = 256;

  logic                          clk;
  logic                          rst;
  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata;
  logic [NUM_SRC*KEEP_WIDTH-1:0] s_tkeep;
  logic [NUM_SRC-1:0]            s_tvalid;
  logic [NUM_SRC-1:0]            s_tlast;
  logic [NUM_SRC-1:0]            s_tuser;
  logic [NUM_SRC-1:0]            s_tready;
  logic [DATA_WIDTH-1:0]         m_tdata;
  logic [KEEP_WIDTH-1:0]         m_tkeep;
  logic                          m_tvalid;
  logic                          m_tlast;
  logic                          m_tuser;
  logic                          m_tready;
  logic                          tx_pause;
  logic [GW-1:0]                 grant_id;
  logic                          busy;
  logic [31:0]                   pkt_cnt;
  logic                          err_overlong;

  fhg_tx_pkt_arbiter #(
    .NUM_SRC   (NUM_SRC),
    .DATA_WIDTH(DATA_WIDTH),
    .KEEP_WIDTH(KEEP_WIDTH),
    .MIN_GAP   (MIN_GAP),
    .MAX_BEATS (MAX_BEATS),
    .GW        (GW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_tdata     (s_tdata),
    .s_tkeep     (s_tkeep),
    .s_tvalid    (s_tvalid),
    .s_tlast     (s_tlast),
    .s_tuser     (s_tuser),
    .s_tready    (s_tready),
    .m_tdata     (m_tdata),
    .m_tkeep     (m_tkeep),
    .m_tvalid    (m_tvalid),
    .m_tlast     (m_tlast),
    .m_tuser     (m_tuser),
    .m_tready    (m_tready),
    .tx_pause    (tx_pause),
    .grant_id    (grant_id),
    .busy        (busy),
    .pkt_cnt     (pkt_cnt),
    .err_overlong(err_overlong)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [1:0]  src;
    logic        last;
    logic        user;
    logic [27:0] tag;
  } beat_t;

  beat_t              smem [NUM_SRC][DEPTH];
  int                 rd [NUM_SRC];
  int                 wr [NUM_SRC];
  beat_t              exp_q[$];
  logic [NUM_SRC-1:0] fire;
  logic               rst_nxt, rdy_nxt, pause_nxt;
  int                 n_pass, n_total;
  int                 cyc, last_tlast_cyc, pkt_first_cyc, cur_len;
  bit                 in_pkt;
  int                 gap_q[$], span_q[$], len_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic push_pkt(input int src, input int pkt, input int n, input bit user_last);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.src  = 2'(src);
      b.last = (i == n - 1);
      b.user = user_last && (i == n - 1);
      b.tag  = {8'(pkt), 20'(i)};
      smem[src][wr[src] % DEPTH] = b;
      wr[src]++;
      exp_q.push_back(b);
    end
  endtask

  task automatic drive_sources();
    for (int k = 0; k < NUM_SRC; k++) begin
      logic [31:0] w;
      beat_t b;
      if (rd[k] < wr[k]) begin
        b = smem[k][rd[k] % DEPTH];
        s_tvalid[k] = 1'b1;
      end else begin
        b = '0;
        s_tvalid[k] = 1'b0;
      end
      w = b;
      s_tdata[k*DATA_WIDTH +: DATA_WIDTH] = {(DATA_WIDTH/32){w}};
      s_tkeep[k*KEEP_WIDTH +: KEEP_WIDTH] = {(KEEP_WIDTH/32){~w}};
      s_tlast[k] = b.last;
      s_tuser[k] = b.user;
    end
  endtask

  task automatic monitor();
    beat_t       e;
    logic [31:0] w, nw;
    logic [3:0]  exp_rdy;
    if (!busy) begin
      chk("idle_tvalid", 64'(m_tvalid), 64'd0);
      chk("idle_tready", 64'(s_tready), 64'd0);
    end else if (exp_q.size() != 0) begin
      exp_rdy = m_tready ? (4'b0001 << exp_q[0].src) : 4'b0000;
      chk("xfer_tready", 64'(s_tready), 64'(exp_rdy));
    end
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_beat", 64'd1, 64'd0);
      end else begin
        e  = exp_q.pop_front();
        w  = e;
        nw = ~w;
        chk("beat_data", m_tdata[63:0], {w, w});
        chk("beat_keep", 64'(m_tkeep[31:0]), 64'(nw));
        chk("beat_last", 64'(m_tlast), 64'(e.last));
        chk("beat_user", 64'(m_tuser), 64'(e.user));
        chk("beat_grant", 64'(grant_id), 64'(e.src));
      end
      if (!in_pkt) begin
        in_pkt = 1'b1;
        gap_q.push_back(cyc - last_tlast_cyc - 1);
        pkt_first_cyc = cyc;
        cur_len = 0;
      end
      cur_len++;
      if (m_tlast) begin
        in_pkt = 1'b0;
        last_tlast_cyc = cyc;
        span_q.push_back(cyc - pkt_first_cyc + 1);
        len_q.push_back(cur_len);
      end
    end
  endtask

  // One bus cycle: inputs change just after the rising edge, outputs are
  // sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (fire[k]) rd[k]++;
    end
    rst      = rst_nxt;
    m_tready = rdy_nxt;
    tx_pause = pause_nxt;
    drive_sources();
    @(negedge clk);
    fire = s_tvalid & s_tready;
    monitor();
  endtask

  task automatic wait_drain(input string tag, input int max);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || busy) && i < max) begin
      step();
      i++;
    end
    chk(tag, 64'(exp_q.size() == 0 && !busy), 64'd1);
  endtask

  task automatic wait_beats(input string tag, input int n);
    int i;
    i = 0;
    while (!(in_pkt && cur_len == n) && i < 300) begin
      step();
      i++;
    end
    chk(tag, 64'(in_pkt && cur_len == n), 64'd1);
  endtask

  task automatic clear_stats();
    gap_q.delete();
    span_q.delete();
    len_q.delete();
  endtask

  initial begin
    rst = 1'b1; rst_nxt = 1'b1; rdy_nxt = 1'b1; pause_nxt = 1'b0;
    m_tready = 1'b1; tx_pause = 1'b0; fire = '0;
    s_tdata = '0; s_tkeep = '0; s_tvalid = '0; s_tlast = '0; s_tuser = '0;
    n_pass = 0; n_total = 0; cyc = 0; last_tlast_cyc = 0;
    pkt_first_cyc = 0; cur_len = 0; in_pkt = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      rd[k] = 0;
      wr[k] = 0;
    end
    drive_sources();

    // Reset state
    repeat (3) step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_err", 64'(err_overlong), 64'd0);
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    rst_nxt = 1'b0;
    step();

    // Source 0 alone, 64-beat packet, with grant latency
    clear_stats();
    push_pkt(0, 1, 64, 1'b0);
    step();
    chk("t1_lat_idle", 64'(busy), 64'd0);
    step();
    chk("t1_lat_xfer", 64'(busy), 64'd1);
    chk("t1_lat_tvalid", 64'(m_tvalid), 64'd1);
    wait_drain("t1_drain", 200);
    chk("t1_len", 64'(len_q[0]), 64'd64);
    chk("t1_span", 64'(span_q[0]), 64'd64);
    chk("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);
    chk("t1_grant", 64'(grant_id), 64'd0);
    chk("t1_err", 64'(err_overlong), 64'd0);

    // Fresh priority, then all four sources requesting together
    rst_nxt = 1'b1;
    step();
    rst_nxt = 1'b0;
    step();
    chk("t2_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    clear_stats();
    push_pkt(0, 2, 3, 1'b0);
    push_pkt(1, 2, 3, 1'b1);
    push_pkt(2, 2, 3, 1'b0);
    push_pkt(3, 2, 3, 1'b0);
    push_pkt(0, 3, 3, 1'b0);
    for (int i = 0; i < 100 && len_q.size() < 4; i++) step();
    chk("t2_four_pkts", 64'(len_q.size()), 64'd4);
    step();
    chk("t2_pkt_cnt4", 64'(pkt_cnt), 64'd4);
    wait_drain("t2_drain", 100);
    chk("t2_pkt_cnt5", 64'(pkt_cnt), 64'd5);
    for (int i = 1; i <= 4; i++) chk("t2_gap", 64'(gap_q[i]), 64'd2);
    for (int i = 0; i < 5; i++) chk("t2_span", 64'(span_q[i]), 64'd3);

    // Backpressure toggling during source 2's packet
    clear_stats();
    push_pkt(2, 4, 4, 1'b1);
    for (int i = 0; i < 60 && (exp_q.size() != 0 || busy); i++) begin
      rdy_nxt = ~rdy_nxt;
      step();
    end
    chk("t3_drain", 64'(exp_q.size()), 64'd0);
    rdy_nxt = 1'b1;
    chk("t3_len", 64'(len_q[0]), 64'd4);
    chk("t3_pkt_cnt", 64'(pkt_cnt), 64'd6);

    // Pause in IDLE blocks the grant; pause mid-packet does not
    clear_stats();
    pause_nxt = 1'b1;
    push_pkt(1, 5, 3, 1'b0);
    repeat (3) begin
      step();
      chk("t4_paused_busy", 64'(busy), 64'd0);
    end
    pause_nxt = 1'b0;
    step();
    chk("t4_release_idle", 64'(busy), 64'd0);
    step();
    chk("t4_release_xfer", 64'(busy), 64'd1);
    pause_nxt = 1'b1;
    wait_drain("t4_drain", 50);
    chk("t4_len", 64'(len_q[0]), 64'd3);
    chk("t4_pkt_cnt", 64'(pkt_cnt), 64'd7);
    pause_nxt = 1'b0;
    step();

    // Overlong packet from source 3
    clear_stats();
    push_pkt(3, 6, 65, 1'b0);
    wait_beats("t5_reach64", 64);
    chk("t5_err_before", 64'(err_overlong), 64'd0);
    step();
    chk("t5_err_set", 64'(err_overlong), 64'd1);
    wait_drain("t5_drain", 100);
    chk("t5_len", 64'(len_q[0]), 64'd65);
    chk("t5_pkt_cnt", 64'(pkt_cnt), 64'd8);
    repeat (5) step();
    chk("t5_err_sticky", 64'(err_overlong), 64'd1);

    // Reset in the middle of a packet
    clear_stats();
    push_pkt(0, 7, 20, 1'b0);
    wait_beats("t6_reach9", 9);
    rst_nxt = 1'b1;
    step();
    for (int k = 0; k < NUM_SRC; k++) rd[k] = wr[k];
    fire = '0;
    exp_q.delete();
    in_pkt = 1'b0;
    rst_nxt = 1'b0;
    step();
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_tvalid", 64'(m_tvalid), 64'd0);
    chk("t6_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("t6_err", 64'(err_overlong), 64'd0);
    chk("t6_grant", 64'(grant_id), 64'd0);
    clear_stats();
    push_pkt(0, 8, 1, 1'b0);
    push_pkt(1, 8, 1, 1'b1);
    wait_drain("t6_drain", 50);
    chk("t6_single_span", 64'(span_q[0]), 64'd1);
    chk("t6_pkt_cnt2", 64'(pkt_cnt), 64'd2);
    chk("t6_last_grant", 64'(grant_id), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fhg_tx_pkt_arbiter.md
# fhg_tx_pkt_arbiter

Packet-level round-robin arbiter that shares the single 1024-bit CASPER TX AXI-Stream port of the 400G adapter between NUM_SRC packet sources. It sits directly upstream of the TX adapter's casper_tx_* inputs. It holds a grant from first beat to tlast, so packets never interleave. It stops issuing new grants while the DCMAC TX path reports almost-full, inserts a programmable inter-packet idle gap, and keeps packet and error statistics.

## Interface
- NUM_SRC, 4: number of requesting sources, 2..8
- DATA_WIDTH, 1024: tdata width per source
- KEEP_WIDTH, 128: tkeep width, DATA_WIDTH/8
- MIN_GAP, 1: idle cycles forced after each packet's tlast beat, 0..15
- MAX_BEATS, 64: longest legal packet in beats (8192 B / 128 B)
- GW: derived grant-index width, max(1, ceil(log2 NUM_SRC))

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_tdata  in  NUM_SRC*DATA_WIDTH  source k occupies slice [k*DATA_WIDTH +: DATA_WIDTH]
- s_tkeep  in  NUM_SRC*KEEP_WIDTH  per-source tkeep, sliced the same way
- s_tvalid  in  NUM_SRC  per-source valid
- s_tlast  in  NUM_SRC  per-source last
- s_tuser  in  NUM_SRC  per-source user/error
- s_tready  out  NUM_SRC  per-source ready
- m_tdata  out  DATA_WIDTH  to adapter casper_tx_tdata
- m_tkeep  out  KEEP_WIDTH  to adapter casper_tx_tkeep
- m_tvalid  out  1  to adapter casper_tx_tvalid
- m_tlast  out  1  to adapter casper_tx_tlast
- m_tuser  out  1  to adapter casper_tx_tuser
- m_tready  in  1  from adapter casper_tx_tready
- tx_pause  in  1  OR of dcmac_tx_af, registered externally
- grant_id  out  GW  index of the current or last granted source
- busy  out  1  high while in XFER
- pkt_cnt  out  32  packets completed, i.e. tlast beats accepted
- err_overlong  out  1  sticky; a packet exceeded MAX_BEATS beats

## Operation
- FSM states: IDLE, XFER, GAP.
- IDLE:
  - If tx_pause=0 and any s_tvalid is set, pick the first valid source scanning last_grant+1, last_grant+2, ... with modulo-NUM_SRC wrap.
  - Register that source as grant_id, clear beat_cnt, go to XFER.
  - Otherwise stay in IDLE.
- XFER:
  - Output mux: m_tdata, m_tkeep, m_tvalid, m_tlast and m_tuser come combinationally from source grant_id.
  - s_tready[grant_id] = m_tready. All other s_tready bits are 0.
  - A beat is accepted when m_tvalid & m_tready; beat_cnt increments on each accepted beat.
  - When the accepted beat has tlast: increment pkt_cnt, set last_grant=grant_id, go to GAP (MIN_GAP>0) or IDLE (MIN_GAP=0).
- GAP: count MIN_GAP cycles, then go to IDLE.
- Outside XFER: m_tvalid=0 and all s_tready=0. m_tdata/m_tkeep still show the slice selected by grant_id and are don't-care.
- tx_pause is sampled only in IDLE. A packet already in progress always runs to tlast; backpressure inside a packet comes only through m_tready.
- Overlong packets: if a beat is accepted while beat_cnt==MAX_BEATS-1 and tlast=0, set err_overlong=1 (sticky until rst). Forwarding continues unchanged; beat_cnt saturates at MAX_BEATS.
- pkt_cnt wraps modulo 2^32.
- The arbiter never modifies data, keep or user bits.

## Timing
- Reset values:
  - state=IDLE, grant_id=0, last_grant=NUM_SRC-1, so source 0 has first priority.
  - busy=0, pkt_cnt=0, err_overlong=0, m_tvalid=0, s_tready=0.
- Grant latency: a source valid in IDLE at cycle t gets its first beat through at cycle t+1 at the earliest.
- Minimum spacing between two packets' transfer cycles: tlast beat, then MIN_GAP GAP cycles, then 1 IDLE cycle. With MIN_GAP=1 that is 2 idle bus cycles.
- Simultaneous requests are resolved in the same cycle by round-robin order.
- tx_pause rising in the same IDLE cycle as a request blocks the grant.
- Single-beat packets (tvalid & tlast on the first beat) are legal: XFER lasts 1 cycle when m_tready=1.
- A source that drops tvalid mid-packet keeps the grant. m_tvalid follows it low, and there is no timeout.
- Reset asserted mid-packet: back to IDLE on the next edge. The partial packet is abandoned and is the source's responsibility.

## Test plan
- Source 0 alone, 64-beat packet, m_tready=1 -> 64 consecutive m_tvalid beats, tlast on beat 64, pkt_cnt=1, grant_id=0, then 2 idle cycles (MIN_GAP=1).
- All 4 sources valid continuously, 3-beat packets -> grant order 0,1,2,3,0 with no interleaving; pkt_cnt=4 after the fourth tlast.
- m_tready toggled 1,0,1,0 during source 2's packet -> every beat delivered exactly once in order; s_tready[2] equals m_tready, other s_tready bits 0.
- tx_pause=1 in IDLE with source 1 valid -> no grant, busy=0. Drop pause -> XFER on the next cycle. Pause raised mid-packet -> packet completes.
- Source 3 sends a 65-beat packet -> err_overlong=1 on accept of beat 64, all 65 beats forwarded, flag stays set until rst.
- rst asserted during beat 10 of a packet -> next cycle state IDLE, m_tvalid=0, pkt_cnt=0, err_overlong=0, and source 0 has priority next.
